clk_div_bank: RTL and testbench
===============================

Name: clk_div_bank

Overview:
Multi-channel, runtime-programmable successor of the single fixed-ratio clock divider. Holds CH_NUM independent counter channels. Each channel produces a divided enable/clock-like level (div) and a one-cycle wrap pulse (tick). Each channel's divide value and high-time are reprogrammable through a valid/ready config port. Updates are glitch-free: they take effect only at a period boundary. Sits between the system clock and slow peripherals (LED blink, UART baud, sampling ticks) in DE10-Lite designs.

Parameters:
CH_NUM, 4, number of divider channels (1..16)
CNT_W, 32, counter/divide-value width
DEF_DIV, 96000000, reset divide value for every channel (period = DEF_DIV+1 cycles)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  CH_NUM  per-channel count enable
sync  in  1  pulse: realign all channels to counter 0
cfg_valid  in  1  config write request
cfg_ready  out  1  config write can be accepted
cfg_ch  in  $clog2(CH_NUM) (min 1)  target channel
cfg_div  in  CNT_W  new divide value
cfg_duty  in  CNT_W  new high-time compare value
div  out  CH_NUM  divided level per channel
tick  out  CH_NUM  one-cycle pulse at end of period

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). All state is cleared on the rst assertion edge.
- Reset values:
  - cnt[i]=0; div_act[i]=DEF_DIV; duty_act[i]=DEF_DIV>>1.
  - Shadow registers equal the active values; pending[i]=0.
  - Outputs: div=all ones, tick=0, cfg_ready=1.
- Counting, when en[i]=1:
  - cnt[i] <= (cnt[i]==div_act[i]) ? 0 : cnt[i]+1.
  - When en[i]=0, cnt[i] holds.
- Outputs, combinational from registers:
  - div[i] = (cnt[i] <= duty_act[i]).
  - tick[i] = en[i] && (cnt[i]==div_act[i]).
  - Period = div_act+1 cycles; high-time = min(duty,div)+1 cycles.
- Config handshake:
  - cfg_ready = !pending[cfg_ch].
  - A transfer occurs when cfg_valid && cfg_ready: the shadow div/duty for cfg_ch are written and pending[cfg_ch] is set.
  - If cfg_ch >= CH_NUM, the transfer is accepted and discarded.
- Apply: on a cycle where tick[i]=1 and pending[i]=1:
  - div_act/duty_act are loaded from the shadow registers.
  - pending[i] is cleared.
  - cnt[i] wraps to 0 as normal.
  - The new period starts with the next count.
- A write accepted in the same cycle as that channel's tick is NOT applied at that tick. It is applied at the following wrap.
- sync=1, regardless of en:
  - All cnt <= 0.
  - Every pending shadow is applied and all pending flags clear.
  - Takes priority over a normal count or wrap in the same cycle.
  - A cfg write in the same cycle as sync is accepted and stays pending.
- Boundaries:
  - div_act=0: cnt stays 0, div=1 constantly, tick=en every cycle.
  - duty_act >= div_act: div constantly 1.
  - Counter never exceeds div_act. Arithmetic is unsigned CNT_W; no wrap past 2^CNT_W-1 is possible.
- Channels are fully independent except for sync and the shared config port.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W default and DEF_DIV default.
  - Typedef cnt_t (logic [CNT_W-1:0]).
  - Struct div_cfg_t {cnt_t div; cnt_t duty;}.
- Sub-module clk_div_ch: one channel containing counter, active/shadow cfg_t, pending flag, div/tick generation and apply logic. Instantiated CH_NUM times via generate.
- The top level does cfg_ch decode, cfg_ready mux and sync fan-out.

Test Plan:
- Reset with DEF_DIV=9 (bench override), en=all 1 -> each div high 5 cycles, low 5 cycles; tick at cycles 9, 19, 29; div=1 and tick=0 while rst=1.
- Write ch1 div=3 duty=0 mid-period -> cfg_ready for ch1 drops the next cycle. ch1 keeps period 10 until its tick, then period 4 with high-time 1; cfg_ready returns to 1. Other channels are unchanged.
- Second write to ch1 while pending -> cfg_ready=0, no transfer; a write to ch2 in the same window is accepted.
- en[0] toggled low for 3 cycles at cnt=4 -> cnt holds at 4, tick delayed by exactly 3 cycles, div level frozen.
- Channels at different phases, pulse sync with ch3 pending div=0 -> all cnt=0 next cycle; all div=1; ch3 div constantly 1 with tick every cycle thereafter.
- Write ch0 in the same cycle as its tick, then set div=duty=5 -> the old period completes once more before the new one applies. With duty>=div, div stays 1 and tick occurs every 6 cycles. Assert rst mid-period -> immediate return to reset values.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults and config types for the programmable clock divider bank.
package clk_div_pkg;
  localparam int          CNT_W_DEF   = 32;
  localparam int unsigned DEF_DIV_DEF = 96000000;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef struct packed {
    cnt_t div;
    cnt_t duty;
  } div_cfg_t;
endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: wrap counter, active/shadow config, boundary-only apply.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             div,
  output logic             tick,
  output logic             pending
);
  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] duty;
  } ch_cfg_t;

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);
  localparam ch_cfg_t          RST_CFG = '{div: RST_DIV, duty: RST_DIV >> 1};

  logic [CNT_W-1:0] cnt;
  ch_cfg_t          act, shd;
  logic             wrap, apply;

  assign wrap  = (cnt == act.div);
  assign tick  = en && wrap;
  assign div   = (cnt <= act.duty);
  // sync flushes the shadow at once; otherwise only at this channel's wrap
  assign apply = pending && (sync || tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      act     <= RST_CFG;
      shd     <= RST_CFG;
      pending <= 1'b0;
    end else begin
      if (sync)    cnt <= '0;
      else if (en) cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (apply)   act <= shd;
      // wr is only granted while !pending, so it never collides with apply
      if (wr) begin
        shd     <= '{div: wr_div, duty: wr_duty};
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// Bank of CH_NUM programmable dividers sharing one config port and a sync pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int          CH_NUM  = 4,
  parameter  int          CNT_W   = CNT_W_DEF,
  parameter  int unsigned DEF_DIV = DEF_DIV_DEF,
  localparam int          CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic [CH_NUM-1:0] div,
  output logic [CH_NUM-1:0] tick
);
  logic [CH_NUM-1:0] pend, wr;
  logic [31:0]       ch_idx;

  assign ch_idx = 32'(cfg_ch);

  // Out-of-range channels match nothing: ready stays 1 and the write is dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH_NUM; i++)
      if (ch_idx == 32'(i)) cfg_ready = !pend[i];
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign wr[g] = cfg_valid && cfg_ready && (ch_idx == 32'(g));

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg_div),
      .wr_duty (cfg_duty),
      .div     (div[g]),
      .tick    (tick[g]),
      .pending (pend[g])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with DEF_DIV=9: vector table plus reset sequences.
module tb_clk_div_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [31:0] cfg_duty;
  logic [3:0]  div;
  logic [3:0]  tick;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  en;
    logic        sync;
    logic        vld;
    logic [1:0]  ch;
    logic [31:0] dv;
    logic [31:0] dt;
    logic [3:0]  xdiv;
    logic [3:0]  xtick;
    logic        xrdy;
  } vec_t;

  vec_t tv[$];

  clk_div_bank #(.CH_NUM(4), .CNT_W(32), .DEF_DIV(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_duty  (cfg_duty),
    .div       (div),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic idle();
    en = 4'hF; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = '0; cfg_duty = '0;
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later.
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
      cyc++;
      idle();
    end
  endtask

  task automatic add(input int c, input logic [3:0] e, input logic s, input logic v,
                     input logic [1:0] ch, input int dv, input int dt,
                     input logic [3:0] xd, input logic [3:0] xt, input logic xr);
    vec_t t;
    t.cyc = c; t.en = e; t.sync = s; t.vld = v; t.ch = ch;
    t.dv = 32'(dv); t.dt = 32'(dt); t.xdiv = xd; t.xtick = xt; t.xrdy = xr;
    tv.push_back(t);
  endtask

  initial begin
    // default period 10: div high cnt 0..4, tick at cnt 9
    add(  0, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1);
    add(  4, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1);
    add(  5, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1);
    add(  9, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1);
    add( 10, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1);
    add( 19, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1);
    add( 29, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1);
    // ch1 -> div 3 duty 0, applied at its tick on cycle 39
    add( 32, 4'hF, 0, 1, 1, 3, 0, 4'hF, 4'h0, 1);
    add( 33, 4'hF, 0, 0, 1, 0, 0, 4'hF, 4'h0, 0);
    add( 39, 4'hF, 0, 0, 1, 0, 0, 4'h0, 4'hF, 0);
    add( 40, 4'hF, 0, 0, 1, 0, 0, 4'hF, 4'h0, 1);
    add( 41, 4'hF, 0, 0, 0, 0, 0, 4'hD, 4'h0, 1);
    add( 43, 4'hF, 0, 0, 0, 0, 0, 4'hD, 4'h2, 1);
    add( 44, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1);
    add( 47, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h2, 1);
    add( 48, 4'hF, 0, 0, 0, 0, 0, 4'h2, 4'h0, 1);
    // ch1 -> 5/2 accepted, 7/3 refused while pending, ch2 -> 4/1 accepted
    add( 50, 4'hF, 0, 1, 1, 5, 2, 4'hD, 4'h0, 1);
    add( 51, 4'hF, 0, 1, 1, 7, 3, 4'hD, 4'h2, 0);
    add( 52, 4'hF, 0, 1, 2, 4, 1, 4'hF, 4'h0, 1);
    add( 53, 4'hF, 0, 0, 2, 0, 0, 4'hF, 4'h0, 0);
    add( 57, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h2, 1);
    add( 59, 4'hF, 0, 0, 0, 0, 0, 4'h2, 4'hD, 1);
    add( 60, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1);
    add( 62, 4'hF, 0, 0, 0, 0, 0, 4'h9, 4'h0, 1);
    add( 63, 4'hF, 0, 0, 0, 0, 0, 4'h9, 4'h2, 1);
    add( 64, 4'hF, 0, 0, 0, 0, 0, 4'hB, 4'h4, 1);
    // en[0] low for 3 cycles at cnt 4: ch0 tick moves from 79 to 82
    add( 74, 4'hE, 0, 0, 0, 0, 0, 4'h9, 4'h4, 1);
    add( 75, 4'hE, 0, 0, 0, 0, 0, 4'h5, 4'h2, 1);
    add( 76, 4'hE, 0, 0, 0, 0, 0, 4'h7, 4'h0, 1);
    add( 77, 4'hF, 0, 0, 0, 0, 0, 4'h3, 4'h0, 1);
    add( 78, 4'hF, 0, 0, 0, 0, 0, 4'h2, 4'h0, 1);
    add( 79, 4'hF, 0, 0, 0, 0, 0, 4'h0, 4'hC, 1);
    add( 82, 4'hF, 0, 0, 0, 0, 0, 4'hA, 4'h1, 1);
    // ch3 -> div 0 pending, then sync realigns everything
    add( 85, 4'hF, 0, 1, 3, 0, 0, 4'h5, 4'h0, 1);
    add( 86, 4'hF, 0, 0, 3, 0, 0, 4'h5, 4'h0, 0);
    add( 87, 4'hF, 1, 0, 3, 0, 0, 4'h1, 4'h2, 0);
    add( 88, 4'hF, 0, 0, 3, 0, 0, 4'hF, 4'h8, 1);
    add( 89, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h8, 1);
    add( 90, 4'hF, 0, 0, 0, 0, 0, 4'hB, 4'h8, 1);
    add( 91, 4'h7, 0, 0, 0, 0, 0, 4'h9, 4'h0, 1);
    // ch0 write on its own tick: old period runs once more, then 5/5
    add( 97, 4'hF, 0, 1, 0, 5, 5, 4'h8, 4'hD, 1);
    add( 98, 4'hF, 0, 0, 0, 0, 0, 4'hD, 4'h8, 0);
    add(103, 4'hF, 0, 0, 0, 0, 0, 4'hC, 4'h8, 0);
    add(107, 4'hF, 0, 0, 0, 0, 0, 4'hA, 4'hD, 0);
    add(108, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h8, 1);
    add(113, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h9, 1);
    add(116, 4'hF, 0, 0, 0, 0, 0, 4'h9, 4'h8, 1);
    add(119, 4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h9, 1);

    idle();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_div", 32'(div), 32'hF);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_rdy", 32'(cfg_ready), 32'h1);
    rst = 1'b0;
    cyc = 0;

    for (int k = 0; k < tv.size(); k++) begin
      go(tv[k].cyc);
      en = tv[k].en; sync = tv[k].sync; cfg_valid = tv[k].vld;
      cfg_ch = tv[k].ch; cfg_div = tv[k].dv; cfg_duty = tv[k].dt;
      #1;
      chk("div", 32'(div), 32'(tv[k].xdiv));
      chk("tick", 32'(tick), 32'(tv[k].xtick));
      chk("cfg_ready", 32'(cfg_ready), 32'(tv[k].xrdy));
    end

    // asynchronous reset mid-period, no clock edge in between
    go(120);
    #4 rst = 1'b1;
    #1;
    chk("arst_div", 32'(div), 32'hF);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_rdy", 32'(cfg_ready), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_div", 32'(div), 32'hF);
    rst = 1'b0;
    cyc = 0;
    // defaults restored: every channel back to period 10, ch3 no longer div 0
    go(5);
    #1;
    chk("post_div5", 32'(div), 32'h0);
    chk("post_tick5", 32'(tick), 32'h0);
    go(9);
    #1;
    chk("post_tick9", 32'(tick), 32'hF);
    go(10);
    #1;
    chk("post_div10", 32'(div), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
